// File: rtl/neuron_sequencer.sv
// Per-tick sequencer: snapshots axon spikes, then for each neuron fetches its
// connection row, loads the potential, scans every axon and strobes write-back.
module neuron_sequencer #(
    parameter int unsigned NUM_AXONS   = 256,
    parameter int unsigned NUM_NEURONS = 256,
    parameter int unsigned NUM_WEIGHTS = 4
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        tick,
    input  logic [NUM_AXONS-1:0]                        axon_spikes,
    input  logic [NUM_AXONS*((NUM_WEIGHTS > 1) ? $clog2(NUM_WEIGHTS) : 1)-1:0] axon_types,
    output logic [((NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1)-1:0] csram_addr,
    input  logic [NUM_AXONS-1:0]                        csram_connections,
    output logic                                        next_neuron,
    output logic                                        integrator_reg_en,
    output logic                                        write_current_potential,
    output logic [((NUM_WEIGHTS > 1) ? $clog2(NUM_WEIGHTS) : 1)-1:0] neuron_instruction,
    output logic [((NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1)-1:0] neuron_addr,
    output logic                                        potential_we,
    output logic                                        busy,
    output logic                                        done,
    output logic                                        tick_overrun
);

    localparam int unsigned AW = (NUM_AXONS > 1) ? $clog2(NUM_AXONS) : 1;
    localparam int unsigned NW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    localparam int unsigned TW = (NUM_WEIGHTS > 1) ? $clog2(NUM_WEIGHTS) : 1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        LOAD      = 3'd2,
        INTEGRATE = 3'd3,
        WRITE     = 3'd4,
        DONE      = 3'd5
    } state_t;

    state_t                 state;
    logic [NW-1:0]          neuron_cnt;
    logic [AW-1:0]          axon_cnt;
    logic [NUM_AXONS-1:0]   spike_snap;
    logic [NUM_AXONS-1:0]   conn_row;

    logic [AW-1:0]          axon_nxt;
    logic [NW-1:0]          neuron_nxt;
    logic                   last_axon;
    logic                   last_neuron;

    assign axon_nxt    = axon_cnt + AW'(1);
    assign neuron_nxt  = neuron_cnt + NW'(1);
    assign last_axon   = (axon_cnt == AW'(NUM_AXONS - 1));
    assign last_neuron = (neuron_cnt == NW'(NUM_NEURONS - 1));

    // Any tick outside IDLE (DONE included) is dropped and flagged the same cycle.
    assign tick_overrun = tick && (state != IDLE);

    // Sequencer; outputs are registered with the values belonging to the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                   <= IDLE;
            neuron_cnt              <= '0;
            axon_cnt                <= '0;
            spike_snap              <= '0;
            conn_row                <= '0;
            csram_addr              <= '0;
            neuron_addr             <= '0;
            next_neuron             <= 1'b0;
            integrator_reg_en       <= 1'b0;
            write_current_potential <= 1'b0;
            neuron_instruction      <= '0;
            potential_we            <= 1'b0;
            busy                    <= 1'b0;
            done                    <= 1'b0;
        end else begin
            next_neuron             <= 1'b0;
            integrator_reg_en       <= 1'b0;
            write_current_potential <= 1'b0;
            neuron_instruction      <= '0;
            potential_we            <= 1'b0;
            done                    <= 1'b0;

            case (state)
                IDLE: begin
                    if (tick) begin
                        spike_snap  <= axon_spikes;
                        neuron_cnt  <= '0;
                        csram_addr  <= '0;
                        neuron_addr <= '0;
                        busy        <= 1'b1;
                        state       <= FETCH;
                    end
                end

                FETCH: begin
                    next_neuron             <= 1'b1;
                    integrator_reg_en       <= 1'b1;
                    write_current_potential <= 1'b1;
                    state                   <= LOAD;
                end

                LOAD: begin
                    // Row is only now arriving, so axon 0 uses the live SRAM data.
                    conn_row           <= csram_connections;
                    axon_cnt           <= '0;
                    integrator_reg_en  <= spike_snap[0] & csram_connections[0];
                    neuron_instruction <= axon_types[0 +: TW];
                    state              <= INTEGRATE;
                end

                INTEGRATE: begin
                    if (last_axon) begin
                        potential_we <= 1'b1;
                        state        <= WRITE;
                    end else begin
                        axon_cnt           <= axon_nxt;
                        integrator_reg_en  <= spike_snap[axon_nxt] & conn_row[axon_nxt];
                        neuron_instruction <= axon_types[int'(axon_nxt)*TW +: TW];
                    end
                end

                WRITE: begin
                    if (last_neuron) begin
                        csram_addr  <= '0;
                        neuron_addr <= '0;
                        done        <= 1'b1;
                        state       <= DONE;
                    end else begin
                        neuron_cnt  <= neuron_nxt;
                        csram_addr  <= neuron_nxt;
                        neuron_addr <= neuron_nxt;
                        state       <= FETCH;
                    end
                end

                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_sequencer.sv
// Directed bench for neuron_sequencer with 4 axons, 2 neurons, 4 axon types.
module tb_neuron_sequencer;

    localparam int unsigned NA  = 4;
    localparam int unsigned NN  = 2;
    localparam int unsigned NWT = 4;
    localparam int unsigned TW  = 2;
    localparam int unsigned NW  = 1;

    logic              clk;
    logic              rst_n;
    logic              tick;
    logic [NA-1:0]     axon_spikes;
    logic [NA*TW-1:0]  axon_types;
    logic [NW-1:0]     csram_addr;
    logic [NA-1:0]     csram_connections;
    logic              next_neuron;
    logic              integrator_reg_en;
    logic              write_current_potential;
    logic [TW-1:0]     neuron_instruction;
    logic [NW-1:0]     neuron_addr;
    logic              potential_we;
    logic              busy;
    logic              done;
    logic              tick_overrun;

    int errors;
    int checks;

    logic [NA-1:0] rows [NN];
    logic [9:0]    exp_a [16];
    logic [9:0]    exp_b [16];
    logic [9:0]    obs;

    neuron_sequencer #(
        .NUM_AXONS   (NA),
        .NUM_NEURONS (NN),
        .NUM_WEIGHTS (NWT)
    ) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .tick                    (tick),
        .axon_spikes             (axon_spikes),
        .axon_types              (axon_types),
        .csram_addr              (csram_addr),
        .csram_connections       (csram_connections),
        .next_neuron             (next_neuron),
        .integrator_reg_en       (integrator_reg_en),
        .write_current_potential (write_current_potential),
        .neuron_instruction      (neuron_instruction),
        .neuron_addr             (neuron_addr),
        .potential_we            (potential_we),
        .busy                    (busy),
        .done                    (done),
        .tick_overrun            (tick_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Connection SRAM: one-cycle read latency.
    always @(posedge clk) csram_connections <= rows[csram_addr];

    // {busy, done, potential_we, next_neuron, reg_en, wcp, instr[1:0], neuron_addr, csram_addr}
    assign obs = {busy, done, potential_we, next_neuron, integrator_reg_en,
                  write_current_potential, neuron_instruction, neuron_addr, csram_addr};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Issue one tick and compare every cycle; optionally pulse reset or a second tick.
    task automatic run_tick(input logic [NA-1:0] spk, input int use_b, input int ovr_at,
                            input int rst_at);
        logic [9:0] e;
        @(posedge clk); #1;
        tick        = 1'b1;
        axon_spikes = spk;
        @(posedge clk); #1;
        tick        = 1'b0;
        axon_spikes = '0;
        for (int c = 1; c <= 16; c++) begin
            if (c > 1) begin
                @(posedge clk); #1;
            end
            tick = (c == ovr_at);
            #1;
            if (c == rst_at) begin
                rst_n = 1'b0;
                #1;
                check($sformatf("rst_outs_c%0d", c), 32'(obs), 32'd0);
                check("rst_overrun", 32'(tick_overrun), 32'd0);
                for (int k = 0; k < 3; k++) begin
                    @(posedge clk); #1;
                    check($sformatf("rst_hold_%0d", k), 32'({obs, tick_overrun}), 32'd0);
                end
                rst_n = 1'b1;
                return;
            end
            e = (use_b != 0) ? exp_b[c-1] : exp_a[c-1];
            check($sformatf("outs_c%0d", c), 32'(obs), 32'(e));
            check($sformatf("overrun_c%0d", c), 32'(tick_overrun), 32'(c == ovr_at));
        end
        tick = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        // Axon a has type a; neuron 0 row 1110, neuron 1 row 0101.
        exp_a = '{10'b1000000000, 10'b1001110000, 10'b1000000000, 10'b1000100100,
                  10'b1000001000, 10'b1000101100, 10'b1010000000, 10'b1000000011,
                  10'b1001110011, 10'b1000100011, 10'b1000000111, 10'b1000001011,
                  10'b1000001111, 10'b1010000011, 10'b1100000000, 10'b0000000000};
        // All-zero rows: reg_en only in LOAD cycles.
        exp_b = '{10'b1000000000, 10'b1001110000, 10'b1000000000, 10'b1000000100,
                  10'b1000001000, 10'b1000001100, 10'b1010000000, 10'b1000000011,
                  10'b1001110011, 10'b1000000011, 10'b1000000111, 10'b1000001011,
                  10'b1000001111, 10'b1010000011, 10'b1100000000, 10'b0000000000};
        rows[0]     = 4'b1110;
        rows[1]     = 4'b0101;
        axon_types  = {2'd3, 2'd2, 2'd1, 2'd0};
        axon_spikes = '0;
        tick        = 1'b0;
        rst_n       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outs", 32'(obs), 32'd0);
        check("reset_overrun", 32'(tick_overrun), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_outs", 32'(obs), 32'd0);

        // Main run with a mid-sequence tick and spikes dropped after the snapshot.
        run_tick(4'b1011, 0, 5, 0);

        rows[0] = 4'b0000;
        rows[1] = 4'b0000;
        run_tick(4'b1111, 1, 0, 0);

        // Reset during neuron 1 integration, then a full clean restart.
        rows[0] = 4'b1110;
        rows[1] = 4'b0101;
        run_tick(4'b1011, 0, 0, 11);
        @(posedge clk); #1;
        check("post_rst_idle", 32'(obs), 32'd0);
        run_tick(4'b1011, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/neuron_sequencer.md
Name: neuron_sequencer

Overview:
- Per-tick control stage directly upstream of the neuron block.
- On each tick it snapshots the axon spike vector and walks every neuron in order. For each neuron it fetches the synapse connection row, loads the stored potential into the integrator, then steps through all axons, enabling integration where a spike coincides with a connection and selecting the weight by axon type. It finishes with a potential write-back strobe.
- Output drives the neuron block's integrator controls and the potential/spike write-back path.

Parameters:
NUM_AXONS, 256, axons per core; scan length per neuron.
NUM_NEURONS, 256, neurons per core.
NUM_WEIGHTS, 4, axon types; neuron_instruction width = $clog2(NUM_WEIGHTS).

Ports:
clk  input  1  core clock; all state on rising edge.
rst_n  input  1  asynchronous, active-low reset.
tick  input  1  single-cycle pulse starting a core time step.
axon_spikes  input  NUM_AXONS  spike per axon; sampled only on an accepted tick.
axon_types  input  $clog2(NUM_WEIGHTS)*NUM_AXONS  type of axon a at bits [a*TW +: TW]; static during a tick.
csram_addr  output  $clog2(NUM_NEURONS)  connection-row address (= current neuron).
csram_connections  input  NUM_AXONS  row for csram_addr; valid exactly 1 cycle after the address is presented.
next_neuron  output  1  integrator selects current_potential (load).
integrator_reg_en  output  1  integrator register update enable.
write_current_potential  output  1  forces weight to zero during load.
neuron_instruction  output  $clog2(NUM_WEIGHTS)  axon type of the axon being integrated.
neuron_addr  output  $clog2(NUM_NEURONS)  neuron being processed.
potential_we  output  1  write-back strobe; write_potential/spike_out are valid this cycle.
busy  output  1  high from accepted tick until done.
done  output  1  single-cycle pulse after the last neuron's write-back.
tick_overrun  output  1  single-cycle pulse when a tick arrives while busy.

Behaviour:
- Reset (async assert, sync release): state IDLE; neuron and axon counters 0; spike snapshot and connection row 0. All outputs 0, including addresses.
- States: IDLE, FETCH, LOAD, INTEGRATE, WRITE, DONE.
- IDLE: on tick, latch axon_spikes into snapshot, neuron counter := 0, go to FETCH, busy := 1.
- FETCH (1 cycle): csram_addr = neuron_addr = neuron counter. Go to LOAD.
- LOAD (1 cycle):
  - latch csram_connections into the row register;
  - assert next_neuron = integrator_reg_en = write_current_potential = 1;
  - axon counter := 0; go to INTEGRATE.
- INTEGRATE (exactly NUM_AXONS cycles, axon a = counter):
  - integrator_reg_en = snapshot[a] & row[a];
  - neuron_instruction = type of axon a; next_neuron = write_current_potential = 0.
  - At a = NUM_AXONS-1 go to WRITE, else a+1.
  - Scan length is fixed regardless of sparsity.
- WRITE (1 cycle): potential_we = 1, neuron_addr held, integrator_reg_en = 0.
  - If neuron counter = NUM_NEURONS-1 go to DONE; else increment and go to FETCH.
- DONE (1 cycle): done = 1, busy := 0, go to IDLE.
- A tick in DONE is treated as busy (overrun).
- Outputs:
  - csram_addr and neuron_addr are held stable from FETCH through WRITE for the same neuron.
  - neuron_instruction = 0 outside INTEGRATE.
- Latency: tick to first potential_we = NUM_AXONS+3 cycles. Neuron period = NUM_AXONS+3 cycles. tick to done = NUM_NEURONS*(NUM_AXONS+3)+1 cycles.
- Tick while busy: ignored (snapshot unchanged, sequence continues); tick_overrun pulses that cycle.
- axon_spikes changing mid-tick has no effect, since only the snapshot is used.
- Counters wrap never occurs: both are compared for their terminal value before incrementing.
- Reset asserted mid-operation: immediate return to IDLE with all outputs 0. No done pulse and no partial write-back.

Test Plan:
- Params NUM_AXONS=4, NUM_NEURONS=2, NUM_WEIGHTS=4; reset then idle. -> All outputs 0; busy=0.
- tick with axon_spikes=4'b1011, types {3,2,1,0} (a0=0…a3=3), row n0=4'b1110 -> integrator_reg_en high only for a1 (instr 1) and a3 (instr 3).
  - Neuron 0: FETCH at cycle 1, LOAD at cycle 2 with next_neuron/write_current_potential high, potential_we at cycle 7.
  - Neuron 1: potential_we at cycle 14. done at cycle 15.
- Second tick at cycle 5 of the above run -> tick_overrun pulse at cycle 5; sequence and snapshot unaffected; done still at cycle 15.
- axon_spikes toggled to 4'b0000 one cycle after tick -> integration identical to using 4'b1011.
- Row all zeros -> integrator_reg_en asserted only in LOAD cycles; potential_we still issued per neuron.
- rst_n low during INTEGRATE of neuron 1 -> all outputs 0 immediately, no done. Next tick restarts at neuron 0 with a full sequence.
